// File: rtl/addsub_pkg.sv
// Shared types and the per-lane arithmetic used by addsub_pipe.
package addsub_pkg;

    // Widest lane the arithmetic helper supports; each lane zero-extends its
    // operands up to this width and the caller passes the real lane width.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,  // (a+b) mod 2^W, flag = carry out
        OP_SUB  = 2'b01,  // (a-b) mod 2^W, flag = borrow
        OP_ADDS = 2'b10,  // min(a+b, 2^W-1), flag = clamped
        OP_SUBS = 2'b11   // max(a-b, 0), flag = clamped
    } op_e;

    // One lane result: indicator bit plus the W-bit value in the low bits of y.
    typedef struct packed {
        logic             flag;
        logic [MAX_W-1:0] y;
    } lane_res_t;

    // Pure W+1-bit lane arithmetic. a and b must already be zero above bit w-1,
    // so bit w of the widened sum is exactly the carry out of a w-bit add.
    function automatic lane_res_t lane_calc(
        input op_e              op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      w
    );
        lane_res_t        res;
        logic [MAX_W:0]   sum;
        logic [MAX_W:0]   diff;
        logic [MAX_W-1:0] mask;
        logic             carry;
        logic             borrow;

        mask   = {MAX_W{1'b1}} >> (MAX_W - w);
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        carry  = sum[w];
        borrow = (a < b);

        res.flag = 1'b0;
        res.y    = '0;
        case (op)
            OP_ADD: begin
                res.y    = sum[MAX_W-1:0] & mask;
                res.flag = carry;
            end
            OP_SUB: begin
                res.y    = diff[MAX_W-1:0] & mask;
                res.flag = borrow;
            end
            OP_ADDS: begin
                res.y    = carry ? mask : (sum[MAX_W-1:0] & mask);
                res.flag = carry;
            end
            default: begin
                res.y    = borrow ? '0 : (diff[MAX_W-1:0] & mask);
                res.flag = borrow;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// One valid/ready register slice. It loads whenever it is empty or its current
// contents leave this cycle, so a chain of these has no bubbles under flow.
module addsub_stage #(
    parameter int PW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic          valid_reg;
    logic [PW-1:0] data_reg;

    // Combinational ready: free slot now, or the held item drains this edge.
    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Slice register: capture on a load, otherwise hold (stable under stall).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// Multi-lane add/subtract pipeline. Lane arithmetic is evaluated at acceptance
// and captured in stage 0; later stages only delay the {flag, y} payload.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int W     = 10,
    parameter int LANES = 2,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] y,
    output logic [LANES-1:0]   flag
);

    // Each lane carries W result bits plus its indicator bit.
    localparam int LW = W + 1;
    localparam int PW = LANES * LW;

    // Stage k consumes index k and produces index k+1; index 0 is the block
    // input and index DEPTH is the block output.
    logic          stg_valid [DEPTH+1];
    logic          stg_ready [DEPTH+1];
    logic [PW-1:0] stg_data  [DEPTH+1];

    logic [PW-1:0] calc_data;
    lane_res_t     lane_res [LANES];

    // Per-lane arithmetic feeding stage 0.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_calc
        assign lane_res[gi] = lane_calc(op_e'(op),
                                        MAX_W'(a[gi*W +: W]),
                                        MAX_W'(b[gi*W +: W]),
                                        W);
        assign calc_data[gi*LW +: LW] = {lane_res[gi].flag, lane_res[gi].y[W-1:0]};
    end

    assign stg_valid[0]     = in_valid;
    assign stg_data[0]      = calc_data;
    assign in_ready         = stg_ready[0];
    assign stg_ready[DEPTH] = out_ready;

    // Register chain; ready ripples back combinationally from out_ready.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        addsub_stage #(
            .PW(PW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (stg_valid[gi]),
            .in_ready  (stg_ready[gi]),
            .in_data   (stg_data[gi]),
            .out_valid (stg_valid[gi+1]),
            .out_ready (stg_ready[gi+1]),
            .out_data  (stg_data[gi+1])
        );
    end

    assign out_valid = stg_valid[DEPTH];

    // Unpack the last stage into the lane result and indicator buses.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_out
        assign y[gi*W +: W] = stg_data[DEPTH][gi*LW +: W];
        assign flag[gi]     = stg_data[DEPTH][gi*LW + W];
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: DEPTH=2 main instance plus DEPTH=1 and
// DEPTH=4 instances sharing the same stimulus for latency/capacity checks.
module tb_addsub_pipe;

    localparam int W     = 10;
    localparam int LANES = 2;
    localparam int PW    = LANES * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [PW-1:0] a = '0;
    logic [PW-1:0] b = '0;

    logic          rdy_d1, rdy_d2, rdy_d4;
    logic          ov_d1, ov_d2, ov_d4;
    logic [PW-1:0] y_d1, y_d2, y_d4;
    logic [1:0]    fl_d1, fl_d2, fl_d4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] op;
        logic [9:0] a1, b1, a0, b0, ey1, ey0;
        logic [1:0] ef;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    addsub_pipe #(.W(W), .LANES(LANES), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d2), .op(op),
        .a(a), .b(b), .out_valid(ov_d2), .out_ready(out_ready), .y(y_d2), .flag(fl_d2)
    );
    addsub_pipe #(.W(W), .LANES(LANES), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d1), .op(op),
        .a(a), .b(b), .out_valid(ov_d1), .out_ready(out_ready), .y(y_d1), .flag(fl_d1)
    );
    addsub_pipe #(.W(W), .LANES(LANES), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d4), .op(op),
        .a(a), .b(b), .out_valid(ov_d4), .out_ready(out_ready), .y(y_d4), .flag(fl_d4)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] exp_y(input vec_t v);
        return {v.ey1, v.ey0};
    endfunction

    task automatic drive_vec(input vec_t v);
        op       = v.op;
        a        = {v.a1, v.a0};
        b        = {v.b1, v.b0};
        in_valid = 1'b1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One vector into an idle DEPTH=2 pipe; result must show exactly 2 cycles later.
    task automatic run_single(input string tag, input vec_t v);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive_vec(v);
            else        in_valid = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            if (c < 2) begin
                check_val({tag, "_early_valid"}, 64'(ov_d2), 64'(0));
            end else begin
                check_val({tag, "_valid"}, 64'(ov_d2), 64'(1));
                check_val({tag, "_y"}, 64'(y_d2), 64'(exp_y(v)));
                check_val({tag, "_flag"}, 64'(fl_d2), 64'(v.ef));
            end
        end
    endtask

    initial begin
        vec_t v;
        int p, q, cnt1, cnt2, cnt4, lat1, lat2, lat4, stale;

        //            op     a1        b1        a0        b0        ey1       ey0       ef
        tbl[0] = '{2'd0, 10'd100,  10'd200,  10'd600,  10'd500,  10'd300,  10'd76,   2'b01};
        tbl[1] = '{2'd1, 10'd10,   10'd3,    10'd0,    10'd1,    10'd7,    10'd1023, 2'b01};
        tbl[2] = '{2'd2, 10'd512,  10'd512,  10'd511,  10'd512,  10'd1023, 10'd1023, 2'b10};
        tbl[3] = '{2'd3, 10'd0,    10'd0,    10'd1,    10'd2,    10'd0,    10'd0,    2'b01};
        tbl[4] = '{2'd0, 10'd1023, 10'd1023, 10'd0,    10'd0,    10'd1022, 10'd0,    2'b10};
        tbl[5] = '{2'd1, 10'd1023, 10'd1023, 10'd200,  10'd300,  10'd0,    10'd924,  2'b01};
        tbl[6] = '{2'd2, 10'd1000, 10'd23,   10'd1000, 10'd24,   10'd1023, 10'd1023, 2'b01};
        tbl[7] = '{2'd3, 10'd1023, 10'd0,    10'd300,  10'd299,  10'd1023, 10'd1,    2'b00};

        // Reset state, asserted asynchronously before any clock edge.
        #1 rst = 1'b1;
        #2;
        check_val("reset_out_valid", 64'(ov_d2), 64'(0));
        check_val("reset_y", 64'(y_d2), 64'(0));
        check_val("reset_flag", 64'(fl_d2), 64'(0));
        check_val("reset_in_ready", 64'(rdy_d2), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed single vectors through each mode.
        v = '{2'd0, 10'd3, 10'd4, 10'd1023, 10'd1, 10'd7, 10'd0,    2'b01}; run_single("add_wrap", v);
        v = '{2'd2, 10'd3, 10'd4, 10'd1023, 10'd1, 10'd7, 10'd1023, 2'b01}; run_single("add_sat", v);
        v = '{2'd3, 10'd9, 10'd2, 10'd5,    10'd7, 10'd7, 10'd0,    2'b01}; run_single("sub_sat", v);
        v = '{2'd1, 10'd9, 10'd2, 10'd5,    10'd7, 10'd7, 10'd1022, 2'b01}; run_single("sub_wrap", v);

        // Back-to-back stream of 8 with out_ready held high.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c < 8) drive_vec(tbl[c]);
            else       in_valid = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            if (c < 8) check_val($sformatf("stream_in_ready_%0d", c), 64'(rdy_d2), 64'(1));
            if (c >= 2) begin
                check_val($sformatf("stream_valid_%0d", c - 2), 64'(ov_d2), 64'(1));
                check_val($sformatf("stream_y_%0d", c - 2), 64'(y_d2), 64'(exp_y(tbl[c-2])));
                check_val($sformatf("stream_flag_%0d", c - 2), 64'(fl_d2), 64'(tbl[c-2].ef));
            end else begin
                check_val($sformatf("stream_early_valid_%0d", c), 64'(ov_d2), 64'(0));
            end
        end

        // Stall with out_ready low, then release and drain in order.
        do_reset();
        p = 0;
        q = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 5);
            if (p < 6) drive_vec(tbl[p]);
            else       in_valid = 1'b0;
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                check_val($sformatf("stall_valid_c%0d", c), 64'(ov_d2), 64'(1));
                check_val($sformatf("stall_y_stable_c%0d", c), 64'(y_d2), 64'(exp_y(tbl[0])));
            end
            if (c == 4) begin
                check_val("stall_accepted", 64'(p), 64'(2));
                check_val("stall_in_ready", 64'(rdy_d2), 64'(0));
            end
            if (c == 5) check_val("resume_same_cycle", 64'(rdy_d2), 64'(1));
            if (in_valid && rdy_d2) p++;
            if (ov_d2 && out_ready && q < 6) begin
                check_val($sformatf("drain_y_%0d", q), 64'(y_d2), 64'(exp_y(tbl[q])));
                check_val($sformatf("drain_flag_%0d", q), 64'(fl_d2), 64'(tbl[q].ef));
                q++;
            end
        end
        check_val("drain_accepted", 64'(p), 64'(6));
        check_val("drain_count", 64'(q), 64'(6));

        // Capacity per depth with out_ready low, then simultaneous accept/drain.
        do_reset();
        cnt1 = 0;
        cnt2 = 0;
        cnt4 = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            drive_vec(tbl[0]);
            out_ready = 1'b0;
            @(negedge clk);
            if (rdy_d1) cnt1++;
            if (rdy_d2) cnt2++;
            if (rdy_d4) cnt4++;
        end
        check_val("capacity_d1", 64'(cnt1), 64'(1));
        check_val("capacity_d2", 64'(cnt2), 64'(2));
        check_val("capacity_d4", 64'(cnt4), 64'(4));
        check_val("full_in_ready_d4", 64'(rdy_d4), 64'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        check_val("full_release_ready_d1", 64'(rdy_d1), 64'(1));
        check_val("full_release_ready_d2", 64'(rdy_d2), 64'(1));
        check_val("full_release_ready_d4", 64'(rdy_d4), 64'(1));

        // Latency per depth for one isolated vector.
        do_reset();
        lat1 = -1;
        lat2 = -1;
        lat4 = -1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive_vec(tbl[4]);
            else        in_valid = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            if (ov_d1 && lat1 < 0) begin
                lat1 = c;
                check_val("lat_y_d1", 64'(y_d1), 64'(exp_y(tbl[4])));
            end
            if (ov_d2 && lat2 < 0) lat2 = c;
            if (ov_d4 && lat4 < 0) begin
                lat4 = c;
                check_val("lat_y_d4", 64'(y_d4), 64'(exp_y(tbl[4])));
                check_val("lat_flag_d4", 64'(fl_d4), 64'(tbl[4].ef));
            end
        end
        check_val("latency_d1", 64'(lat1), 64'(1));
        check_val("latency_d2", 64'(lat2), 64'(2));
        check_val("latency_d4", 64'(lat4), 64'(4));

        // Reset with two vectors in flight.
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            drive_vec(tbl[c]);
            out_ready = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", 64'(ov_d2), 64'(0));
        check_val("midrst_y", 64'(y_d2), 64'(0));
        check_val("midrst_flag", 64'(fl_d2), 64'(0));
        check_val("midrst_in_ready", 64'(rdy_d2), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            if (ov_d2 || ov_d1 || ov_d4) stale++;
        end
        check_val("midrst_no_stale", 64'(stale), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
